// File: rtl/ann_pkg.sv
// Shared defaults, FSM state type and saturation limits for the neuron accumulator.
package ann_pkg;

  localparam int IN_W_DEF  = 20;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Largest (neg=0) or smallest (neg=1) value representable in a w-bit signed word.
  function automatic longint sat_limit(input int w, input bit neg);
    longint mag;
    mag = longint'(1) << (w - 1);
    return neg ? -mag : mag - 1;
  endfunction

endpackage

// File: rtl/acc_shift_sat.sv
// Combinational rescale of the accumulator: arithmetic right shift, then signed saturation.
// NEURON_ACC_RELU_EN: clamp negative results to zero instead of passing them through.
module acc_shift_sat
  import ann_pkg::*;
#(
  parameter int ACC_W      = 30,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  logic signed [ACC_W-1:0] shifted;
  longint                  shifted_l;

  assign shifted = acc_i >>> FRAC_SHIFT;

  always_comb begin
    shifted_l = longint'(shifted);
    data_o    = OUT_W'(shifted);
    sat_o     = 1'b0;
    if (shifted_l > sat_limit(OUT_W, 1'b0)) begin
      data_o = OUT_W'(sat_limit(OUT_W, 1'b0));
      sat_o  = 1'b1;
    end else if (shifted_l < sat_limit(OUT_W, 1'b1)) begin
      data_o = OUT_W'(sat_limit(OUT_W, 1'b1));
      sat_o  = 1'b1;
    end
`ifdef NEURON_ACC_RELU_EN
    if (shifted_l < 0) begin
      data_o = '0;
      sat_o  = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums one neuron's partial-sum stream plus bias, then emits a rescaled, saturated activation.
// Optional ReLU clamp in the rescale path is enabled by NEURON_ACC_RELU_EN.
//
// state | meaning
// IDLE  | waiting for the first beat of a neuron (bias is sampled with it)
// ACCUM | adding further beats until in_last or the term count is reached
// FINAL | one cycle to rescale/saturate the sum into the output register
// OUT   | result held on out_*, waiting for out_ready
module neuron_accumulator
  import ann_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int N_TERMS    = 392,
  parameter int ACC_W      = 30,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = OUT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_last,
  input  logic signed [IN_W-1:0] bias_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                   out_sat,
  output logic                   out_len_err
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     term_err_q, term_err_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_len_err_q, out_len_err_d;
  logic signed [OUT_W-1:0]  scaled_data;
  logic                     scaled_sat;
  logic                     accept;
  logic                     at_count;

  acc_shift_sat #(
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .OUT_W      (OUT_W)
  ) u_shift_sat (
    .acc_i  (acc_q),
    .data_o (scaled_data),
    .sat_o  (scaled_sat)
  );

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign at_count = (cnt_inc == CNT_W'(N_TERMS));

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    term_err_d    = term_err_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sat_d     = out_sat_q;
    out_len_err_d = out_len_err_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = (state_q == IDLE) ? ACC_W'(in_data) + ACC_W'(bias_in)
                                    : acc_q + ACC_W'(in_data);
          cnt_d = cnt_inc;
          // Terminate on whichever comes first; only a last flag on the final count is clean.
          if (in_last || at_count) begin
            state_d    = FINAL;
            term_err_d = !(in_last && at_count);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      FINAL: begin
        out_data_d    = scaled_data;
        out_sat_d     = scaled_sat;
        out_len_err_d = term_err_q;
        out_valid_d   = 1'b1;
        state_d       = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      term_err_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      term_err_q    <= term_err_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sat_q     <= out_sat_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sat     = out_sat_q;
  assign out_len_err = out_len_err_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: stream-level reference model on a 4-term instance plus a
// 1-term, shift-8 instance for the floor-rounding case.
module tb_neuron_accumulator;

  localparam int NT = 4;

  logic clk, rst;

  logic                a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
  logic                a_out_sat, a_out_len_err;
  logic signed [19:0]  a_in_data, a_bias;
  logic signed [15:0]  a_out_data;

  logic                b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic                b_out_sat, b_out_len_err;
  logic signed [19:0]  b_in_data, b_bias;
  logic signed [15:0]  b_out_data;

  neuron_accumulator #(.IN_W(20), .N_TERMS(NT), .ACC_W(30), .FRAC_SHIFT(0), .OUT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .bias_in(a_bias), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat), .out_len_err(a_out_len_err)
  );

  neuron_accumulator #(.IN_W(20), .N_TERMS(1), .ACC_W(30), .FRAC_SHIFT(8), .OUT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .bias_in(b_bias), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat), .out_len_err(b_out_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the stream rules say the outputs must be, kept as plain arithmetic.
  longint m_sum = 0, m_data = 0;
  int     m_cnt = 0;
  bit     m_collect = 1, m_calc = 0, m_valid = 0, m_sat = 0, m_err = 0, m_fresh = 1;

  function automatic void rescale(input longint acc, input int sh,
                                  output longint d, output bit s);
    longint v;
    v = acc >>> sh;
    s = 1'b0;
    d = v;
    if (v > 32767) begin d = 32767; s = 1'b1; end
    else if (v < -32768) begin d = -32768; s = 1'b1; end
`ifdef NEURON_ACC_RELU_EN
    if (v < 0) begin d = 0; s = 1'b0; end
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_collect = 1; m_calc = 0; m_valid = 0;
      m_data = 0; m_sat = 0; m_err = 0; m_fresh = 1;
    end else if (m_valid) begin
      if (a_out_ready) begin
        m_valid   = 0;
        m_collect = 1;
      end
    end else if (m_calc) begin
      m_calc  = 0;
      m_valid = 1;
    end else if (m_collect && a_in_valid) begin
      if (m_cnt == 0) m_sum = a_bias;
      m_sum = m_sum + a_in_data;
      m_cnt++;
      if (a_in_last || m_cnt == NT) begin
        rescale(m_sum, 0, m_data, m_sat);
        m_err     = !(a_in_last && m_cnt == NT);
        m_collect = 0;
        m_calc    = 1;
        m_fresh   = 0;
        m_cnt     = 0;
      end
    end
  end

  // Hand-computed expectations for each emitted neuron, pinning the model.
  int lit_d[16];
  bit lit_s[16], lit_e[16];
  int lit_wr = 0;
  int lit_rd = 0;
  bit pinned = 0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a_in_ready", longint'(a_in_ready), longint'(m_collect));
    chk("a_out_valid", longint'(a_out_valid), longint'(m_valid));
    if (m_valid || m_fresh) begin
      chk("a_out_data", longint'(a_out_data), m_data);
      chk("a_out_sat", longint'(a_out_sat), longint'(m_sat));
      chk("a_out_len_err", longint'(a_out_len_err), longint'(m_err));
    end
    if (m_valid && !pinned) begin
      pinned = 1;
      if (lit_rd < lit_wr) begin
        chk("lit_data", longint'(a_out_data), longint'(lit_d[lit_rd]));
        chk("lit_sat", longint'(a_out_sat), longint'(lit_s[lit_rd]));
        chk("lit_len_err", longint'(a_out_len_err), longint'(lit_e[lit_rd]));
      end else begin
        chk("lit_unexpected_output", 1, 0);
      end
      lit_rd++;
    end
    if (!m_valid) pinned = 0;
    if (b_out_valid) begin
      chk("b_out_data_floor", longint'(b_out_data), -1);
      chk("b_out_sat", longint'(b_out_sat), 0);
      chk("b_out_len_err", longint'(b_out_len_err), 0);
    end
  end

  task automatic beat_a(input int d, input bit last, input int b);
    int k;
    a_in_valid = 1'b1;
    a_in_data  = 20'(d);
    a_in_last  = last;
    a_bias     = 20'(b);
    k = 0;
    while (!a_in_ready) begin
      @(negedge clk);
      k++;
      if (k > 20) begin
        $display("FAIL beat_wait: in_ready stuck got=0 want=1");
        $fatal(1, "input wait expired");
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic get_a(input int d, input bit s, input bit e, input int hold);
    int k;
    lit_d[lit_wr] = d;
    lit_s[lit_wr] = s;
    lit_e[lit_wr] = e;
    lit_wr++;
    k = 0;
    while (!a_out_valid) begin
      @(negedge clk);
      k++;
      if (k > 10) begin
        $display("FAIL out_wait: out_valid got=0 want=1");
        $fatal(1, "output wait expired");
      end
    end
    repeat (hold) @(negedge clk);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_bias = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_bias = '0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // One-term neuron, shift 8: -1 >>> 8 floors to -1.
    b_in_valid = 1; b_in_data = -20'sd1; b_in_last = 1; b_bias = '0;
    @(negedge clk);
    b_in_valid = 0; b_in_last = 0;
    k = 0;
    while (!b_out_valid) begin
      @(negedge clk);
      k++;
      if (k > 10) begin
        $display("FAIL b_out_wait: out_valid got=0 want=1");
        $fatal(1, "output wait expired");
      end
    end
    b_out_ready = 1;
    @(negedge clk);
    b_out_ready = 0;

    // Nominal neuron with a long backpressure hold.
    beat_a(100, 0, 10); beat_a(-20, 0, 0); beat_a(5, 0, 0); beat_a(7, 1, 0);
    get_a(102, 0, 0, 10);

    beat_a(524287, 0, 0); beat_a(524287, 0, 0); beat_a(524287, 0, 0); beat_a(524287, 1, 0);
    get_a(32767, 1, 0, 1);

    beat_a(-524288, 0, 0); beat_a(-524288, 0, 0); beat_a(-524288, 0, 0); beat_a(-524288, 1, 0);
`ifdef NEURON_ACC_RELU_EN
    get_a(0, 0, 0, 0);
`else
    get_a(-32768, 1, 0, 0);
`endif

    beat_a(3, 0, 0); beat_a(4, 1, 0);
    get_a(7, 0, 1, 2);

    beat_a(1, 0, 0); beat_a(2, 0, 0); beat_a(3, 0, 0); beat_a(4, 0, 0);
    get_a(10, 0, 1, 0);

    // Abort mid-neuron; the partial sum must not leak into the next one.
    beat_a(5, 0, 0); beat_a(6, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    beat_a(1, 0, 0); beat_a(1, 0, 0); beat_a(1, 0, 0); beat_a(1, 1, 0);
    get_a(4, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
